// File: rtl/dmem_arbiter.sv
// Data memory arbiter: shares the single-port data memory between the MEM
// stage (port 0) and the DMA/debug loader (port 1). Port 0 has fixed
// priority, and an anti-starvation counter forces port 1 through after
// STARVE_LIMIT back-to-back port 0 wins. Reads are sequenced through the
// memory's MEM_LATENCY. Optional macro DMEM_ARB_PERF_EN adds saturating
// conflict/stall performance counters.
module dmem_arbiter #(
    parameter int unsigned MEM_LATENCY  = 1,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        p0_req,
    input  logic        p0_we,
    input  logic [31:0] p0_addr,
    input  logic [31:0] p0_wdata,
    output logic        p0_gnt,
    output logic        p0_rvalid,
    output logic [31:0] p0_rdata,
    input  logic        p1_req,
    input  logic        p1_we,
    input  logic [31:0] p1_addr,
    input  logic [31:0] p1_wdata,
    output logic        p1_gnt,
    output logic        p1_rvalid,
    output logic [31:0] p1_rdata,
    output logic        stall_m,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
`ifdef DMEM_ARB_PERF_EN
    ,
    output logic [31:0] perf_conflict_cnt,
    output logic [31:0] perf_stall_cnt
`endif
);

    localparam logic [2:0] LAT_INIT   = 3'(MEM_LATENCY);
    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE,
        RWAIT,
        RESP
    } state_t;

    state_t     state;
    logic [2:0] latCnt;
    logic [3:0] starveCnt;
    logic       owner;
    logic       arbActive;
    logic       forceP1;

    // Arbitration: only in IDLE and only out of reset, so every output is 0 while rst is low
    always_comb begin
        arbActive = rst && (state == IDLE);
        forceP1   = (starveCnt == STARVE_MAX);
        p1_gnt    = arbActive && p1_req && (!p0_req || forceP1);
        p0_gnt    = arbActive && p0_req && !p1_gnt;
        mem_en    = p0_gnt || p1_gnt;
        mem_we    = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (p0_gnt) begin
            mem_we    = p0_we;
            mem_addr  = p0_addr;
            mem_wdata = p0_wdata;
        end else if (p1_gnt) begin
            mem_we    = p1_we;
            mem_addr  = p1_addr;
            mem_wdata = p1_wdata;
        end
        stall_m = rst && p0_req && !((p0_gnt && p0_we) || p0_rvalid);
    end

    // Transaction FSM, read-data capture and starvation tracking
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            latCnt    <= '0;
            starveCnt <= '0;
            owner     <= 1'b0;
            p0_rvalid <= 1'b0;
            p1_rvalid <= 1'b0;
            p0_rdata  <= '0;
            p1_rdata  <= '0;
        end else begin
            if (!p1_req || p1_gnt) begin
                starveCnt <= '0;
            end else if (p0_gnt && starveCnt != STARVE_MAX) begin
                starveCnt <= starveCnt + 4'd1;
            end

            case (state)
                IDLE: begin
                    if (mem_en) begin
                        owner <= p1_gnt;
                        if (!mem_we) begin
                            state  <= RWAIT;
                            latCnt <= LAT_INIT;
                        end
                    end
                end
                RWAIT: begin
                    // latCnt reaches 1 in cycle T+MEM_LATENCY, when mem_rdata is valid
                    if (latCnt == 3'd1) begin
                        if (owner) begin
                            p1_rdata  <= mem_rdata;
                            p1_rvalid <= 1'b1;
                        end else begin
                            p0_rdata  <= mem_rdata;
                            p0_rvalid <= 1'b1;
                        end
                        state <= RESP;
                    end else begin
                        latCnt <= latCnt - 3'd1;
                    end
                end
                RESP: begin
                    p0_rvalid <= 1'b0;
                    p1_rvalid <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef DMEM_ARB_PERF_EN
    // Saturating counters of arbitration conflicts and pipeline stall cycles
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_conflict_cnt <= '0;
            perf_stall_cnt    <= '0;
        end else begin
            if (arbActive && p0_req && p1_req && perf_conflict_cnt != '1) begin
                perf_conflict_cnt <= perf_conflict_cnt + 32'd1;
            end
            if (stall_m && perf_stall_cnt != '1) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter (MEM_LATENCY=2, STARVE_LIMIT=4) with a
// latency-accurate memory model and per-port read-data scoreboards.
module tb_dmem_arbiter;

    localparam int LAT    = 2;
    localparam int STARVE = 4;

    logic        clk;
    logic        rst;
    logic        p0Req, p0We, p1Req, p1We;
    logic [31:0] p0Addr, p0Wdata, p1Addr, p1Wdata;
    logic        p0_gnt, p0_rvalid, p1_gnt, p1_rvalid;
    logic [31:0] p0_rdata, p1_rdata;
    logic        stall_m, mem_en, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
`ifdef DMEM_ARB_PERF_EN
    logic [31:0] perfConflict, perfStall;
`endif

    int total = 0;
    int bad   = 0;
    logic [31:0] q0[$];
    logic [31:0] q1[$];
    logic [31:0] memArr[logic [31:0]];
    logic [31:0] rdPipe[LAT];
    logic [31:0] wd[3];

    dmem_arbiter #(
        .MEM_LATENCY (LAT),
        .STARVE_LIMIT(STARVE)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .p0_req   (p0Req),
        .p0_we    (p0We),
        .p0_addr  (p0Addr),
        .p0_wdata (p0Wdata),
        .p0_gnt   (p0_gnt),
        .p0_rvalid(p0_rvalid),
        .p0_rdata (p0_rdata),
        .p1_req   (p1Req),
        .p1_we    (p1We),
        .p1_addr  (p1Addr),
        .p1_wdata (p1Wdata),
        .p1_gnt   (p1_gnt),
        .p1_rvalid(p1_rvalid),
        .p1_rdata (p1_rdata),
        .stall_m  (stall_m),
        .mem_en   (mem_en),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
`ifdef DMEM_ARB_PERF_EN
        ,
        .perf_conflict_cnt(perfConflict),
        .perf_stall_cnt   (perfStall)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: read data appears LAT cycles after the strobe cycle
    assign mem_rdata = rdPipe[LAT-1];
    always @(posedge clk) begin
        if (mem_en && mem_we) memArr[mem_addr] = mem_wdata;
        if (mem_en && !mem_we)
            rdPipe[0] <= memArr.exists(mem_addr) ? memArr[mem_addr] : (mem_addr ^ 32'hA5A5_0000);
        else
            rdPipe[0] <= '0;
        for (int i = 1; i < LAT; i++) rdPipe[i] <= rdPipe[i-1];
    end

    // Scoreboard: every rvalid pulse must match the oldest expected read
    always @(negedge clk) begin
        logic [31:0] e;
        if (p0_rvalid === 1'b1) begin
            total++;
            assert (q0.size() > 0) else begin
                bad++; $error("FAIL p0_unexpected_rvalid observed=%h expected=none", p0_rdata);
            end
            if (q0.size() > 0) begin
                e = q0.pop_front();
                total++;
                assert (p0_rdata === e) else begin
                    bad++; $error("FAIL p0_rdata_sb observed=%h expected=%h", p0_rdata, e);
                end
            end
        end
        if (p1_rvalid === 1'b1) begin
            total++;
            assert (q1.size() > 0) else begin
                bad++; $error("FAIL p1_unexpected_rvalid observed=%h expected=none", p1_rdata);
            end
            if (q1.size() > 0) begin
                e = q1.pop_front();
                total++;
                assert (p1_rdata === e) else begin
                    bad++; $error("FAIL p1_rdata_sb observed=%h expected=%h", p1_rdata, e);
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chkAllZero(input string tag);
        chk({tag, "_p0gnt"}, p0_gnt, 0);
        chk({tag, "_p1gnt"}, p1_gnt, 0);
        chk({tag, "_memen"}, mem_en, 0);
        chk({tag, "_memwe"}, mem_we, 0);
        chk({tag, "_memaddr"}, mem_addr, 0);
        chk({tag, "_p0rv"}, p0_rvalid, 0);
        chk({tag, "_p1rv"}, p1_rvalid, 0);
        chk({tag, "_p0rd"}, p0_rdata, 0);
        chk({tag, "_p1rd"}, p1_rdata, 0);
        chk({tag, "_stall"}, stall_m, 0);
    endtask

    initial begin
        wd[0] = 32'h1234_5678;
        wd[1] = 32'h0BAD_F00D;
        wd[2] = 32'hCAFE_0042;
        memArr[32'h10] = 32'hDEAD_BEEF;
        for (int i = 0; i < LAT; i++) rdPipe[i] = '0;
        rst = 1'b0;
        p0Req = 1'b1; p0We = 1'b0; p0Addr = 32'h10; p0Wdata = '0;
        p1Req = 1'b1; p1We = 1'b0; p1Addr = 32'h14; p1Wdata = '0;

        // Reset: requests present but everything held at 0
        tick(); tick(); #1;
        chkAllZero("rst");
        p0Req = 1'b0; p1Req = 1'b0;
        tick();
        rst = 1'b1;

        // Scenario 1: p0 read of 0x10
        tick();
        p0Req = 1'b1; p0We = 1'b0; p0Addr = 32'h10;
        q0.push_back(32'hDEAD_BEEF);
        #1;
        chk("s1_p0gnt_T", p0_gnt, 1);
        chk("s1_p1gnt_T", p1_gnt, 0);
        chk("s1_memen_T", mem_en, 1);
        chk("s1_memwe_T", mem_we, 0);
        chk("s1_memaddr_T", mem_addr, 32'h10);
        chk("s1_stall_T", stall_m, 1);
        for (int i = 1; i <= LAT; i++) begin
            tick(); #1;
            chk("s1_rvalid_wait", p0_rvalid, 0);
            chk("s1_stall_wait", stall_m, 1);
            chk("s1_memen_wait", mem_en, 0);
        end
        tick(); #1;
        chk("s1_rvalid_resp", p0_rvalid, 1);
        chk("s1_rdata_resp", p0_rdata, 32'hDEAD_BEEF);
        chk("s1_stall_resp", stall_m, 0);
        p0Req = 1'b0;
        tick(); #1;
        chk("s1_rvalid_after", p0_rvalid, 0);
        chk("s1_rdata_hold", p0_rdata, 32'hDEAD_BEEF);

        // Scenario 2: back-to-back p0 writes
        for (int k = 0; k < 3; k++) begin
            tick();
            p0Req = 1'b1; p0We = 1'b1; p0Addr = 32'h20 + 32'(4 * k); p0Wdata = wd[k];
            #1;
            chk("s2_p0gnt", p0_gnt, 1);
            chk("s2_memwe", mem_we, 1);
            chk("s2_memaddr", mem_addr, 32'h20 + 32'(4 * k));
            chk("s2_memwdata", mem_wdata, wd[k]);
            chk("s2_stall", stall_m, 0);
        end
        tick();
        p0Req = 1'b0; p0We = 1'b0;
        #1;
        chk("s2_idle_memen", mem_en, 0);

        // Scenario 3 (fresh reset for perf counters): simultaneous reads
        rst = 1'b0;
        tick(); tick();
        rst = 1'b1;
`ifdef DMEM_ARB_PERF_EN
        chk("s3_perf_conf_rst", perfConflict, 0);
        chk("s3_perf_stall_rst", perfStall, 0);
`endif
        tick();
        p0Req = 1'b1; p0We = 1'b0; p0Addr = 32'h24;
        p1Req = 1'b1; p1We = 1'b0; p1Addr = 32'h28;
        q0.push_back(wd[1]);
        q1.push_back(wd[2]);
        #1;
        chk("s3_p0gnt_T", p0_gnt, 1);
        chk("s3_p1gnt_T", p1_gnt, 0);
        chk("s3_memaddr_T", mem_addr, 32'h24);
        chk("s3_stall_T", stall_m, 1);
        for (int i = 1; i <= LAT; i++) begin
            tick(); #1;
            chk("s3_p1gnt_wait", p1_gnt, 0);
            chk("s3_memen_wait", mem_en, 0);
            chk("s3_stall_wait", stall_m, 1);
        end
        tick(); #1;
        chk("s3_p0rvalid", p0_rvalid, 1);
        chk("s3_p1gnt_resp", p1_gnt, 0);
        chk("s3_stall_resp", stall_m, 0);
        p0Req = 1'b0;
        tick(); #1;
        chk("s3_p1gnt", p1_gnt, 1);
        chk("s3_p1_memaddr", mem_addr, 32'h28);
        chk("s3_p1_memwe", mem_we, 0);
        chk("s3_p1_stall", stall_m, 0);
        for (int i = 1; i <= LAT; i++) begin
            tick(); #1;
            chk("s3_p1rvalid_wait", p1_rvalid, 0);
        end
        tick(); #1;
        chk("s3_p1rvalid", p1_rvalid, 1);
        chk("s3_p1rdata", p1_rdata, wd[2]);
        p1Req = 1'b0;
        tick(); #1;
        chk("s3_p1rvalid_after", p1_rvalid, 0);
`ifdef DMEM_ARB_PERF_EN
        chk("s3_perf_conflict", perfConflict, 1);
        chk("s3_perf_stall", perfStall, 32'(LAT + 1));
`endif

        // Scenario 4: starvation limit forces port 1 through
        tick();
        p1Req = 1'b1; p1We = 1'b1; p1Addr = 32'h40; p1Wdata = 32'h1111_2222;
        p0Req = 1'b1; p0We = 1'b1;
        for (int k = 0; k <= STARVE; k++) begin
            if (k > 0) tick();
            p0Addr = 32'h50 + 32'(4 * k); p0Wdata = 32'hAB00_0000 + 32'(k);
            #1;
            if (k < STARVE) begin
                chk("s4_p0_win", p0_gnt, 1);
                chk("s4_p1_wait", p1_gnt, 0);
                chk("s4_p0_addr", mem_addr, 32'h50 + 32'(4 * k));
            end else begin
                chk("s4_p1_forced", p1_gnt, 1);
                chk("s4_p0_lost", p0_gnt, 0);
                chk("s4_stall_forced", stall_m, 1);
                chk("s4_p1_addr", mem_addr, 32'h40);
                chk("s4_p1_we", mem_we, 1);
                chk("s4_p1_wdata", mem_wdata, 32'h1111_2222);
            end
        end
        tick();
        p1Req = 1'b0; p1We = 1'b0;
        #1;
        chk("s4_p0_resume", p0_gnt, 1);
        chk("s4_p0_resume_addr", mem_addr, 32'h50 + 32'(4 * STARVE));
        chk("s4_stall_resume", stall_m, 0);
        tick();
        p0Req = 1'b0; p0We = 1'b0;
        #1;
        chk("s4_idle", mem_en, 0);

        // Scenario 5: reset during a p1 read drops it
        tick();
        p1Req = 1'b1; p1We = 1'b0; p1Addr = 32'h30;
        #1;
        chk("s5_p1gnt", p1_gnt, 1);
        tick();
        rst = 1'b0;
        #1;
        chkAllZero("s5_rst");
        tick(); #1;
        chk("s5_rst_hold_gnt", p1_gnt, 0);
        p1Req = 1'b0;
        tick();
        rst = 1'b1;
        for (int i = 0; i < LAT + 3; i++) begin
            tick(); #1;
            chk("s5_no_rvalid", p1_rvalid, 0);
        end
        tick();
        p1Req = 1'b1; p1We = 1'b0; p1Addr = 32'h40;
        q1.push_back(32'h1111_2222);
        #1;
        chk("s5_p1gnt_again", p1_gnt, 1);
        for (int i = 1; i <= LAT; i++) begin
            tick(); #1;
            chk("s5_p1rvalid_wait", p1_rvalid, 0);
        end
        tick(); #1;
        chk("s5_p1rvalid", p1_rvalid, 1);
        chk("s5_p1rdata", p1_rdata, 32'h1111_2222);
        p1Req = 1'b0;
        tick(); tick(); #1;

        chk("end_q0_empty", q0.size(), 0);
        chk("end_q1_empty", q1.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory between two requesters: port 0 is the pipeline MEM stage (load/store) and port 1 is the DMA/debug loader.
- Sequences each transaction through the memory's fixed read latency.
- Generates stall_m to freeze the pipeline while a MEM-stage access is pending.
- Sits between the MEM-stage pipeline register logic and the data memory macro.

Parameters:
- MEM_LATENCY, 1: cycles from mem_en to valid mem_rdata for reads; legal range 1..7.
- STARVE_LIMIT, 4: consecutive port-0 wins, with port 1 waiting, after which port 1 is forced; legal range 1..15.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- p0_req  in  1  port 0 request, level; held with payload until done
- p0_we  in  1  port 0 write enable
- p0_addr  in  32  port 0 byte address
- p0_wdata  in  32  port 0 write data
- p0_gnt  out  1  port 0 granted this cycle
- p0_rvalid  out  1  port 0 read data valid, one-cycle pulse
- p0_rdata  out  32  port 0 read data
- p1_req, p1_we, p1_addr, p1_wdata, p1_gnt, p1_rvalid, p1_rdata: same as port 0, for port 1
- stall_m  out  1  freeze IF/ID/EX/MEM pipeline registers
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  32  memory address
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data

Behaviour:
- Reset: state IDLE, starve_cnt=0, all outputs 0, p*_rdata=0.
- Reset mid-transaction: the in-flight read is dropped and no rvalid is issued.
- FSM states: IDLE, RWAIT, RESP.
- Arbitration in IDLE only, combinational:
  - Port 0 wins by fixed priority.
  - Exception: p1_req && starve_cnt==STARVE_LIMIT grants port 1.
  - At most one gnt per cycle.
- Grant cycle T:
  - gnt=1, mem_en=1.
  - mem_we/addr/wdata are taken from the granted port in the same cycle.
  - mem_* outputs are 0 when there is no grant.
- Write grant: complete at T; state stays IDLE, so back-to-back writes run one per cycle.
- Read grant:
  - IDLE -> RWAIT; a latency counter is loaded with MEM_LATENCY.
  - mem_rdata is sampled in cycle T+MEM_LATENCY; state -> RESP.
  - In RESP (cycle T+MEM_LATENCY+1): owner's rvalid=1 for one cycle and rdata shows the sampled value; state -> IDLE.
  - rdata holds until that port's next read completes.
  - Read throughput: one per MEM_LATENCY+2 cycles.
- stall_m = p0_req & ~p0_done, where p0_done = (p0_gnt & p0_we) | p0_rvalid.
  - stall_m is high while port 1 owns the memory and p0_req is set.
- Simultaneous p0_req and p1_req in RWAIT/RESP: no grant; both wait.
- starve_cnt:
  - Increments in IDLE when p0 is granted while p1_req=1; saturates at STARVE_LIMIT.
  - Clears on p1 grant or whenever p1_req=0.
- Requester contract: req and payload are stable from assertion until done; violations are undefined.
- Addresses and data pass through unmodified; byte alignment is the requester's responsibility.

Optional Feature:
DMEM_ARB_PERF_EN:
- Defined:
  - Adds outputs perf_conflict_cnt[31:0], counting IDLE cycles with both reqs high.
  - Adds outputs perf_stall_cnt[31:0], counting cycles with stall_m=1.
  - Both counters saturate at 0xFFFFFFFF and reset to 0.
- Undefined: both ports and all counter logic are absent; there is no behavioural difference otherwise.

Test Plan:
- Reset with MEM_LATENCY=2: p0 read of addr 0x10 (mem returns 0xDEADBEEF).
  - Required: p0_gnt at T; p0_rvalid only at T+3 with p0_rdata=0xDEADBEEF; stall_m=1 for T..T+2, 0 at T+3.
- p0 writes 0x20,0x24,0x28 on consecutive cycles.
  - Required: three gnts in three cycles; mem_we=1 each; stall_m never 1.
- p0 and p1 both request reads in the same IDLE cycle.
  - Required: p0 served first; p1_gnt one cycle after p0_rvalid; p1_rvalid MEM_LATENCY+1 cycles later.
- STARVE_LIMIT=4: p1_req held high while p0 issues continuous writes.
  - Required: p0 wins 4 grants, the 5th grant goes to p1, and stall_m=1 on that cycle.
- Reset asserted at T+1 of a p1 read.
  - Required: all outputs 0 immediately; no p1_rvalid afterwards; next p1 read works normally.
- DMEM_ARB_PERF_EN defined, scenario 3 replayed.
  - Required: perf_conflict_cnt=1; perf_stall_cnt equals the number of cycles stall_m was high.
